// File: rtl/axi_cfg_regfile_if.sv
// AXI4-Lite bus bundle for the configuration register file.
interface axi_cfg_regfile_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID, AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID, WREADY;
  logic [1:0]          BRESP;
  logic                BVALID, BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID, ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID, RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_cfg_regfile.sv
// AXI4-Lite register file: RW control regs to the core, RO status regs from it,
// and a maskable change-detect interrupt over the status regs.
module axi_cfg_regfile #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 9,
  parameter int          NUM_CTRL           = 4,
  parameter int          NUM_STAT           = 4,
  parameter logic [31:0] CTRL_RST_VAL       = 32'h0
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  axi_cfg_regfile_if.slave         s_axi,
  output logic [32*NUM_CTRL-1:0]   ctrl_out,
  input  logic [32*NUM_STAT-1:0]   stat_in,
  output logic                     irq
);
  localparam int          AW  = C_S_AXI_ADDR_WIDTH;
  localparam int          DW  = C_S_AXI_DATA_WIDTH;
  localparam int          WA  = AW - 2;
  localparam logic [6:0]  NC7 = 7'(NUM_CTRL);
  localparam logic [6:0]  NS7 = 7'(NUM_STAT);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [2:0] {K_CTRL, K_STAT, K_ISTS, K_IEN, K_NONE} kind_e;
  typedef struct packed {
    kind_e      kind;
    logic [5:0] idx;
  } dec_t;

  // Word-address decode; anything above the 512-byte window is unmapped.
  function automatic dec_t decode(input logic [WA-1:0] wa);
    dec_t d;
    d.kind = K_NONE;
    d.idx  = wa[5:0];
    if ((wa >> 7) == '0) begin
      if (!wa[6] && {1'b0, wa[5:0]} < NC7)     d.kind = K_CTRL;
      else if (wa[6] && {1'b0, wa[5:0]} < NS7) d.kind = K_STAT;
      else if (wa[6:0] == 7'h7C)               d.kind = K_ISTS;
      else if (wa[6:0] == 7'h7D)               d.kind = K_IEN;
    end
    return d;
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  logic                         aw_held_q, w_held_q;
  logic [WA-1:0]                awaddr_q;
  logic [DW-1:0]                wdata_q;
  logic [DW/8-1:0]              wstrb_q;
  logic                         bvalid_q, rvalid_q;
  logic [1:0]                   bresp_q, rresp_q;
  logic [DW-1:0]                rdata_q;
  logic [NUM_CTRL-1:0][31:0]    ctrl_q, ctrl_d;
  logic [NUM_STAT-1:0][31:0]    stat_q, prev_q;
  logic [NUM_STAT-1:0]          ists_q, ists_d, ien_q, ien_d;
  logic                         irq_q;

  logic        aw_hs, w_hs, ar_hs, commit;
  dec_t        wdec, rdec;
  logic [1:0]  wresp, rresp_d;
  logic [31:0] rdata_d, ien_w, clr_w;
  logic        unused_addr_lsbs;

  assign s_axi.AWREADY = !aw_held_q && !bvalid_q;
  assign s_axi.WREADY  = !w_held_q && !bvalid_q;
  assign s_axi.ARREADY = !rvalid_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;
  assign ctrl_out      = ctrl_q;
  assign irq           = irq_q;

  assign aw_hs  = s_axi.AWVALID && s_axi.AWREADY;
  assign w_hs   = s_axi.WVALID && s_axi.WREADY;
  assign ar_hs  = s_axi.ARVALID && s_axi.ARREADY;
  assign commit = aw_held_q && w_held_q && !bvalid_q;
  assign wdec   = decode(awaddr_q);
  assign rdec   = decode(s_axi.ARADDR[AW-1:2]);
  assign wresp  = (wdec.kind inside {K_CTRL, K_ISTS, K_IEN}) ? OKAY : SLVERR;
  assign unused_addr_lsbs = ^{s_axi.ARADDR[1:0], s_axi.AWADDR[1:0]};

  always_comb begin
    ctrl_d = ctrl_q;
    ien_d  = ien_q;
    ists_d = ists_q;
    ien_w  = bmerge(32'(ien_q), wdata_q, wstrb_q);
    clr_w  = bmerge(32'd0, wdata_q, wstrb_q);
    if (commit) begin
      case (wdec.kind)
        K_CTRL: for (int i = 0; i < NUM_CTRL; i++)
                  if (wdec.idx == 6'(i)) ctrl_d[i] = bmerge(ctrl_q[i], wdata_q, wstrb_q);
        K_IEN:  ien_d  = ien_w[NUM_STAT-1:0];
        K_ISTS: ists_d = ists_q & ~clr_w[NUM_STAT-1:0];
        default: ;
      endcase
    end
    // Set is applied after the W1C clear so a coinciding change is never lost.
    for (int i = 0; i < NUM_STAT; i++)
      if (stat_q[i] != prev_q[i]) ists_d[i] = 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    rresp_d = OKAY;
    case (rdec.kind)
      K_CTRL: for (int i = 0; i < NUM_CTRL; i++) if (rdec.idx == 6'(i)) rdata_d = ctrl_q[i];
      K_STAT: for (int i = 0; i < NUM_STAT; i++) if (rdec.idx == 6'(i)) rdata_d = stat_q[i];
      K_ISTS: rdata_d = 32'(ists_q);
      K_IEN:  rdata_d = 32'(ien_q);
      default: rresp_d = SLVERR;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      ctrl_q    <= {NUM_CTRL{CTRL_RST_VAL}};
      stat_q    <= '0;
      prev_q    <= '0;
      ists_q    <= '0;
      ien_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= s_axi.AWADDR[AW-1:2];
      end else if (commit) aw_held_q <= 1'b0;
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axi.WDATA;
        wstrb_q  <= s_axi.WSTRB;
      end else if (commit) w_held_q <= 1'b0;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wresp;
      end else if (s_axi.BREADY) bvalid_q <= 1'b0;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= rresp_d;
      end else if (s_axi.RREADY) rvalid_q <= 1'b0;
      ctrl_q <= ctrl_d;
      stat_q <= stat_in;
      prev_q <= stat_q;
      ists_q <= ists_d;
      ien_q  <= ien_d;
      irq_q  <= |(ists_q & ien_q);
    end
  end
endmodule
